// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-lite bundle (AR/R/AW/W/B) shared by the arbiter's master-facing and slave-facing ports.
interface axi_lite_arbiter_2to1_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// 2:1 AXI-lite arbiter: IFU (m0, read-only) and LSU (m1) share one memory slave,
// one whole transaction per grant, LSU has fixed priority.
module axi_lite_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_lite_arbiter_2to1_if.slave       m0,
  axi_lite_arbiter_2to1_if.slave       m1,
  axi_lite_arbiter_2to1_if.master      s
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t state;
  logic   ar_done;
  logic   aw_done;
  logic   w_done;

  logic              rd_grant;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ar_hs;
  logic              r_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_open;
  logic              b_hs;

  assign rd_grant = (state == RD0) || (state == RD1);
  assign rd_addr  = (state == RD1) ? m1.araddr : m0.araddr;
  assign rd_data  = s.rdata;

  assign ar_hs  = rd_grant && s.arvalid && s.arready;
  assign r_hs   = rd_grant && s.rvalid && s.rready;
  assign aw_hs  = (state == WR1) && m1.awvalid && !aw_done && s.awready;
  assign w_hs   = (state == WR1) && m1.wvalid && !w_done && s.wready;
  // B opens in the same cycle the later of AW/W completes.
  assign b_open = (state == WR1) && (aw_done || aw_hs) && (w_done || w_hs);
  assign b_hs   = b_open && s.bvalid && s.bready;

  always_comb begin
    s.araddr   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;

    m0.arready = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = '0;
    m0.bvalid  = 1'b0;

    m1.arready = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = '0;
    m1.bvalid  = 1'b0;

    case (state)
      RD0: begin
        s.araddr   = rd_addr;
        s.arvalid  = m0.arvalid && !ar_done;
        m0.arready = s.arready && !ar_done;
        m0.rdata   = rd_data;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
        s.rready   = m0.rready;
      end
      RD1: begin
        s.araddr   = rd_addr;
        s.arvalid  = m1.arvalid && !ar_done;
        m1.arready = s.arready && !ar_done;
        m1.rdata   = rd_data;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
        s.rready   = m1.rready;
      end
      WR1: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid && !aw_done;
        m1.awready = s.awready && !aw_done;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid && !w_done;
        m1.wready  = s.wready && !w_done;
        if (b_open) begin
          s.bready  = m1.bready;
          m1.bvalid = s.bvalid;
          m1.bresp  = s.bresp;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m1.arvalid)                     state <= RD1;
          else if (m1.awvalid || m1.wvalid)   state <= WR1;
          else if (m0.arvalid)                state <= RD0;
        end
        RD0, RD1: begin
          if (r_hs) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end else if (ar_hs) begin
            ar_done <= 1'b1;
          end
        end
        WR1: begin
          if (b_hs) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: grants, priority, write ordering, stalls, async reset.
module tb_axi_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  axi_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  axi_lite_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    m0_bus.araddr = '0; m0_bus.arvalid = 0; m0_bus.rready = 0;
    m0_bus.awaddr = '0; m0_bus.awvalid = 0; m0_bus.wdata = '0;
    m0_bus.wstrb = '0;  m0_bus.wvalid = 0;  m0_bus.bready = 0;
    m1_bus.araddr = '0; m1_bus.arvalid = 0; m1_bus.rready = 0;
    m1_bus.awaddr = '0; m1_bus.awvalid = 0; m1_bus.wdata = '0;
    m1_bus.wstrb = '0;  m1_bus.wvalid = 0;  m1_bus.bready = 0;
    s_bus.arready = 0;  s_bus.rdata = '0;   s_bus.rresp = '0;
    s_bus.rvalid = 0;   s_bus.awready = 0;  s_bus.wready = 0;
    s_bus.bresp = '0;   s_bus.bvalid = 0;

    // reset state, with requests already pending
    m0_bus.arvalid = 1; m1_bus.wvalid = 1;
    #2;
    chk("rst_s_arvalid", s_bus.arvalid, 0);
    chk("rst_s_wvalid",  s_bus.wvalid, 0);
    chk("rst_m0_arready", m0_bus.arready, 0);
    chk("rst_m1_wready", m1_bus.wready, 0);
    m0_bus.arvalid = 0; m1_bus.wvalid = 0;
    cyc(); cyc();
    rst = 1;

    // IFU-only read
    cyc();
    m0_bus.araddr = 32'h8000_0000; m0_bus.arvalid = 1; m0_bus.rready = 1;
    s_bus.arready = 1;
    #1;
    chk("t1_idle_s_arvalid", s_bus.arvalid, 0);
    chk("t1_idle_m0_arready", m0_bus.arready, 0);
    cyc();
    chk("t1_s_arvalid", s_bus.arvalid, 1);
    chk("t1_s_araddr", s_bus.araddr, 32'h8000_0000);
    chk("t1_m0_arready", m0_bus.arready, 1);
    cyc();
    m0_bus.arvalid = 0;
    #1;
    chk("t1_ar_blocked", s_bus.arvalid, 0);
    chk("t1_no_rvalid", m0_bus.rvalid, 0);
    cyc();
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0413; s_bus.rresp = 0;
    #1;
    chk("t1_m0_rvalid", m0_bus.rvalid, 1);
    chk("t1_m0_rdata", m0_bus.rdata, 32'h0000_0413);
    chk("t1_s_rready", s_bus.rready, 1);
    cyc();
    s_bus.rvalid = 0;
    #1;
    chk("t1_idle_rdata", m0_bus.rdata, 0);
    chk("t1_idle_rready", s_bus.rready, 0);
    s_bus.rdata = 0;

    // simultaneous IFU and LSU reads, back-to-back grant
    m0_bus.araddr = 32'h8000_0000; m0_bus.arvalid = 1;
    m1_bus.araddr = 32'h8000_0100; m1_bus.arvalid = 1; m1_bus.rready = 1;
    #1;
    chk("t2_idle_m1_arready", m1_bus.arready, 0);
    cyc();
    chk("t2_s_araddr_lsu", s_bus.araddr, 32'h8000_0100);
    chk("t2_m1_arready", m1_bus.arready, 1);
    chk("t2_m0_arready_a", m0_bus.arready, 0);
    cyc();
    m1_bus.arvalid = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h1111_2222;
    #1;
    chk("t2_m1_rdata", m1_bus.rdata, 32'h1111_2222);
    chk("t2_m0_rvalid", m0_bus.rvalid, 0);
    chk("t2_m0_arready_b", m0_bus.arready, 0);
    cyc();
    s_bus.rvalid = 0;
    #1;
    chk("t2_gap_s_arvalid", s_bus.arvalid, 0);
    chk("t2_gap_m0_arready", m0_bus.arready, 0);
    cyc();
    chk("t2_s_araddr_ifu", s_bus.araddr, 32'h8000_0000);
    chk("t2_ifu_arvalid", s_bus.arvalid, 1);
    chk("t2_ifu_arready", m0_bus.arready, 1);
    cyc();
    m0_bus.arvalid = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0033;
    #1;
    chk("t2_ifu_rdata", m0_bus.rdata, 32'h0000_0033);
    chk("t2_m1_rvalid", m1_bus.rvalid, 0);
    cyc();
    s_bus.rvalid = 0; s_bus.rdata = 0;

    // LSU write, W two cycles ahead of AW
    m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wstrb = 4'hF; m1_bus.wvalid = 1;
    m1_bus.bready = 1; s_bus.wready = 1; s_bus.awready = 1;
    #1;
    chk("t3_idle_s_wvalid", s_bus.wvalid, 0);
    cyc();
    chk("t3_s_wvalid", s_bus.wvalid, 1);
    chk("t3_s_wdata", s_bus.wdata, 32'hDEAD_BEEF);
    chk("t3_s_wstrb", s_bus.wstrb, 4'hF);
    chk("t3_s_awvalid_a", s_bus.awvalid, 0);
    chk("t3_m1_wready", m1_bus.wready, 1);
    cyc();
    m1_bus.wvalid = 0; s_bus.bvalid = 1;
    #1;
    chk("t3_w_blocked", s_bus.wvalid, 0);
    chk("t3_b_gated_valid", m1_bus.bvalid, 0);
    chk("t3_b_gated_ready", s_bus.bready, 0);
    s_bus.bvalid = 0;
    cyc();
    m1_bus.awaddr = 32'h8000_0200; m1_bus.awvalid = 1;
    #1;
    chk("t3_s_awaddr", s_bus.awaddr, 32'h8000_0200);
    chk("t3_s_awvalid_b", s_bus.awvalid, 1);
    chk("t3_bready_same_cycle", s_bus.bready, 1);
    cyc();
    m1_bus.awvalid = 0; s_bus.bvalid = 1; s_bus.bresp = 0;
    #1;
    chk("t3_m1_bvalid", m1_bus.bvalid, 1);
    chk("t3_m1_bresp", m1_bus.bresp, 0);
    chk("t3_aw_blocked", s_bus.awvalid, 0);
    cyc();
    s_bus.bvalid = 0;
    #1;
    chk("t3_idle_bready", s_bus.bready, 0);

    // LSU read beats LSU write; then write with AW and W together, error bresp
    m1_bus.araddr = 32'h0000_0300; m1_bus.arvalid = 1;
    m1_bus.awaddr = 32'h0000_0400; m1_bus.awvalid = 1;
    m1_bus.wdata = 32'h0102_0304; m1_bus.wstrb = 4'h3; m1_bus.wvalid = 1;
    cyc();
    chk("t3b_rd_first", s_bus.arvalid, 1);
    chk("t3b_no_aw", s_bus.awvalid, 0);
    chk("t3b_m1_awready", m1_bus.awready, 0);
    cyc();
    m1_bus.arvalid = 0; s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0055;
    cyc();
    s_bus.rvalid = 0; s_bus.rdata = 0;
    cyc();
    chk("t3b_s_awvalid", s_bus.awvalid, 1);
    chk("t3b_s_wstrb", s_bus.wstrb, 4'h3);
    chk("t3b_bready_joint", s_bus.bready, 1);
    cyc();
    m1_bus.awvalid = 0; m1_bus.wvalid = 0;
    s_bus.bvalid = 1; s_bus.bresp = 2'd2;
    #1;
    chk("t3b_m1_bresp_err", m1_bus.bresp, 2'd2);
    cyc();
    s_bus.bvalid = 0; s_bus.bresp = 0;

    // slave stalls arready for 5 cycles, error rresp
    s_bus.arready = 0;
    m0_bus.araddr = 32'h8000_0040; m0_bus.arvalid = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_s_arvalid", s_bus.arvalid, 1);
      chk("t4_stall_m0_arready", m0_bus.arready, 0);
      cyc();
    end
    s_bus.arready = 1;
    #1;
    chk("t4_m0_arready", m0_bus.arready, 1);
    cyc();
    chk("t4_no_dup_ar", s_bus.arvalid, 0);
    chk("t4_no_dup_arready", m0_bus.arready, 0);
    m0_bus.arvalid = 0;
    s_bus.rvalid = 1; s_bus.rresp = 2'd2; s_bus.rdata = 32'h0000_0ABC;
    #1;
    chk("t4_m0_rresp", m0_bus.rresp, 2'd2);
    chk("t4_m0_rvalid", m0_bus.rvalid, 1);
    cyc();
    s_bus.rvalid = 0; s_bus.rresp = 0; s_bus.rdata = 0;
    #1;
    chk("t4_idle_rvalid", m0_bus.rvalid, 0);

    // async reset during RD1 after AR handshake
    m1_bus.araddr = 32'h0000_0500; m1_bus.arvalid = 1;
    cyc();
    cyc();
    m1_bus.arvalid = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0077;
    #1;
    chk("t5_pre_m1_rvalid", m1_bus.rvalid, 1);
    rst = 0;
    #1;
    chk("t5_rst_m1_rvalid", m1_bus.rvalid, 0);
    chk("t5_rst_m1_rdata", m1_bus.rdata, 0);
    chk("t5_rst_s_rready", s_bus.rready, 0);
    s_bus.rvalid = 0; s_bus.rdata = 0;
    cyc();
    rst = 1;
    m0_bus.araddr = 32'h8000_0080; m0_bus.arvalid = 1;
    cyc();
    chk("t5_post_s_araddr", s_bus.araddr, 32'h8000_0080);
    chk("t5_post_s_arvalid", s_bus.arvalid, 1);
    cyc();
    m0_bus.arvalid = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0099;
    #1;
    chk("t5_post_m0_rdata", m0_bus.rdata, 32'h0000_0099);
    cyc();
    s_bus.rvalid = 0; s_bus.rdata = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Sits directly downstream of the instruction-fetch unit's AXI-lite master port.
- Merges two AXI-lite masters onto the single AXI-lite memory slave: master 0 is the instruction-fetch unit (read-only), master 1 is the load/store unit (read and write).
- Grants one whole transaction at a time.
- Allows exactly one outstanding transaction per grant, matching the multi-cycle core.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels.
- DATA_W, 32, data width of R/W channels; wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- m0_araddr/m0_arvalid/m0_arready  in/in/out  ADDR_W/1/1  IFU read-address channel
- m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  DATA_W/2/1/1  IFU read-data channel
- m1_araddr/m1_arvalid/m1_arready  in/in/out  ADDR_W/1/1  LSU read-address channel
- m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  DATA_W/2/1/1  LSU read-data channel
- m1_awaddr/m1_awvalid/m1_awready  in/in/out  ADDR_W/1/1  LSU write-address channel
- m1_wdata/m1_wstrb/m1_wvalid/m1_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write-data channel
- m1_bresp/m1_bvalid/m1_bready  out/out/in  2/1/1  LSU write-response channel
- s_araddr/s_arvalid/s_arready  out/out/in  ADDR_W/1/1  slave read-address channel
- s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  DATA_W/2/1/1  slave read-data channel
- s_awaddr/s_awvalid/s_awready  out/out/in  ADDR_W/1/1  slave write-address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write-data channel
- s_bresp/s_bvalid/s_bready  in/in/out  2/1/1  slave write-response channel

Behaviour:
- FSM states: IDLE, RD0 (IFU read), RD1 (LSU read), WR1 (LSU write). Sub-flags: ar_done, aw_done, w_done.
- Reset (rst low, async): state=IDLE, all flags=0.
  - Every master- and slave-facing valid/ready output=0.
  - All data/addr/resp outputs=0.
  - Any in-flight transaction is abandoned; the slave shares the same reset.
- IDLE: no channel is forwarded and every ready to the masters is 0. Arbitration is evaluated each cycle:
  - m1_arvalid -> RD1;
  - else m1_awvalid or m1_wvalid -> WR1;
  - else m0_arvalid -> RD0.
  - LSU has fixed priority; an LSU read beats an LSU write when both are presented in the same cycle.
  - Grant takes effect the next cycle. Minimum added latency is 1 cycle on AR/AW, 0 on R/B.
- RDx: routing is combinational.
  - s_araddr=mx_araddr; s_arvalid=mx_arvalid & !ar_done; mx_arready=s_arready & !ar_done.
  - ar_done is set on the AR handshake, so a second AR from the granted master is blocked (arready held 0) until R completes.
  - mx_rdata/mx_rresp/mx_rvalid follow the slave; s_rready=mx_rready.
  - On the R handshake (s_rvalid & s_rready): -> IDLE, ar_done cleared.
  - An R beat arriving before the AR handshake is a slave protocol error and is not required to be handled.
- WR1: AW and W are forwarded independently, each gated by its own done flag (same rule as ar_done).
  - The AW and W handshakes may occur in either order or in the same cycle.
  - B is forwarded once both aw_done and w_done are set, or in the cycle the last of AW/W completes. Otherwise s_bready=0 and m1_bvalid=0.
  - On the B handshake: -> IDLE, flags cleared.
- Non-granted master: arready/awready/wready/rvalid/bvalid=0, rdata/rresp/bresp=0. Its valid stays pending and is never dropped. AXI rules require the master to hold valid and payload stable.
- Slave-side outputs not belonging to the current grant (e.g. AW/W during RDx) are 0.
- Responses: rresp/bresp are passed through unmodified. An error response still completes the transaction normally.
- No starvation guarantee for the IFU beyond the multi-cycle core never presenting concurrent requests. Fairness is not required.

Test Plan:
- IFU only: m0_araddr=0x8000_0000, arvalid at cycle 0, slave arready=1, rdata=0x0000_0413 two cycles after AR -> s_arvalid first seen cycle 1; m0_rvalid with rdata 0x0000_0413; FSM back to IDLE the cycle after R handshake.
- Simultaneous m0_arvalid and m1_arvalid (m1_araddr=0x8000_0100) -> LSU granted first, m0_arready=0 throughout. IFU granted on the cycle after the LSU R handshake, and its address 0x8000_0000 then appears on s_araddr.
- LSU write with W before AW: wdata=0xDEAD_BEEF, wstrb=0xF, awaddr=0x8000_0200 two cycles later -> s_wdata/s_wstrb forwarded at once, s_awaddr later. m1_bvalid only after both handshakes; bresp=0 passed through.
- Slave holds arready=0 for 5 cycles, then responds with rresp=2 -> m0_arvalid stays high, no duplicate AR after the handshake, m0_rresp=2, return to IDLE.
- rst asserted low during RD1 after the AR handshake -> all outputs 0 immediately (async), state IDLE. After release, a fresh m0 request is served normally.
- Back-to-back: LSU read completes while m0_arvalid is already high -> exactly one IDLE cycle, then IFU grant; no lost or duplicated AR.
